// File: rtl/as2650_timer_block.sv
// AS2650 IO-bus timer block: NUM_TIMERS 16-bit down counters with prescaler, reload and irq.
// Define TIMER_BLOCK_PWM_EN to add per-timer compare registers and the pwm_out outputs.
module as2650_timer_block #(
  parameter int unsigned NUM_TIMERS = 2,
  parameter logic [7:0]  ID_VALUE   = 8'h54
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  bus_cyc,
  input  logic                  bus_we,
  input  logic [5:0]            bus_addr,
  input  logic [7:0]            bus_data_in,
  output logic [7:0]            bus_data_out,
  output logic [NUM_TIMERS-1:0] irq,
  output logic [NUM_TIMERS-1:0] pwm_out
);

  logic [5:0]  r_ctrl    [NUM_TIMERS];
  logic [15:0] r_reload  [NUM_TIMERS];
  logic [15:0] r_count   [NUM_TIMERS];
  logic [7:0]  r_staging [NUM_TIMERS];
  logic [7:0]  r_shadow  [NUM_TIMERS];
  logic [6:0]  r_presc   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] r_ovf;
  logic [NUM_TIMERS-1:0] r_irq;
  logic                  r_rd_q;

  logic [5:0]  w_ctrl_nxt    [NUM_TIMERS];
  logic [15:0] w_reload_nxt  [NUM_TIMERS];
  logic [15:0] w_count_nxt   [NUM_TIMERS];
  logic [7:0]  w_staging_nxt [NUM_TIMERS];
  logic [7:0]  w_shadow_nxt  [NUM_TIMERS];
  logic [6:0]  w_presc_nxt   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] w_ovf_nxt;
  logic [NUM_TIMERS-1:0] w_ovf_set;
  logic [NUM_TIMERS-1:0] w_ovf_clr;
  logic [NUM_TIMERS-1:0] w_tick;
  logic [NUM_TIMERS-1:0] w_irq_nxt;

`ifdef TIMER_BLOCK_PWM_EN
  logic [15:0] r_cmp     [NUM_TIMERS];
  logic [15:0] w_cmp_nxt [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] r_pwm;
  logic [NUM_TIMERS-1:0] w_pwm_nxt;
`endif

  logic [2:0] w_idx;
  logic [2:0] w_off;
  logic       w_wr;
  logic       w_rd;

  assign w_idx = bus_addr[5:3];
  assign w_off = bus_addr[2:0];
  assign w_wr  = bus_cyc && bus_we;
  assign w_rd  = bus_cyc && !bus_we;

  always_comb begin
    w_ctrl_nxt    = r_ctrl;
    w_reload_nxt  = r_reload;
    w_count_nxt   = r_count;
    w_staging_nxt = r_staging;
    w_shadow_nxt  = r_shadow;
    w_presc_nxt   = r_presc;
    w_ovf_set     = '0;
    w_ovf_clr     = '0;
    w_ovf_nxt     = '0;
    w_tick        = '0;
    w_irq_nxt     = '0;
`ifdef TIMER_BLOCK_PWM_EN
    w_cmp_nxt     = r_cmp;
    w_pwm_nxt     = '0;
`endif
    for (int n = 0; n < NUM_TIMERS; n++) begin
      w_tick[n] = r_ctrl[n][0] && (r_presc[n] == ((7'd1 << r_ctrl[n][5:3]) - 7'd1));
      if (!r_ctrl[n][0] || w_tick[n]) w_presc_nxt[n] = '0;
      else                            w_presc_nxt[n] = r_presc[n] + 7'd1;

      if (w_tick[n]) begin
        if (r_count[n] != '0) begin
          w_count_nxt[n] = r_count[n] - 16'd1;
        end else begin
          w_count_nxt[n] = r_reload[n];
          w_ovf_set[n]   = 1'b1;
          if (r_ctrl[n][1]) w_ctrl_nxt[n][0] = 1'b0;
        end
      end

      // Bus writes come after the counter update so a written CTRL or COUNT wins.
      if (w_wr && (w_idx == 3'(n))) begin
        case (w_off)
          3'd0: w_ctrl_nxt[n]         = bus_data_in[5:0];
          3'd1: w_reload_nxt[n][7:0]  = bus_data_in;
          3'd2: w_reload_nxt[n][15:8] = bus_data_in;
          3'd3: w_staging_nxt[n]      = bus_data_in;
          3'd4: begin
            w_count_nxt[n] = {bus_data_in, r_staging[n]};
            w_presc_nxt[n] = '0;
          end
          3'd5: w_ovf_clr[n] = bus_data_in[0];
`ifdef TIMER_BLOCK_PWM_EN
          3'd6: w_cmp_nxt[n][7:0]  = bus_data_in;
          3'd7: w_cmp_nxt[n][15:8] = bus_data_in;
`endif
          default: ;
        endcase
      end

      // Latch the high byte only on the first cycle of a COUNT_LO read.
      if (w_rd && !r_rd_q && (w_idx == 3'(n)) && (w_off == 3'd3)) begin
        w_shadow_nxt[n] = r_count[n][15:8];
      end

      w_ovf_nxt[n] = (r_ovf[n] && !w_ovf_clr[n]) || w_ovf_set[n];
      w_irq_nxt[n] = r_ovf[n] && r_ctrl[n][2];
`ifdef TIMER_BLOCK_PWM_EN
      w_pwm_nxt[n] = r_ctrl[n][0] && (r_count[n] < r_cmp[n]);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_rd_q <= 1'b0;
      r_ovf  <= '0;
      r_irq  <= '0;
      for (int n = 0; n < NUM_TIMERS; n++) begin
        r_ctrl[n]    <= '0;
        r_reload[n]  <= '0;
        r_count[n]   <= '0;
        r_staging[n] <= '0;
        r_shadow[n]  <= '0;
        r_presc[n]   <= '0;
      end
`ifdef TIMER_BLOCK_PWM_EN
      r_pwm <= '0;
      for (int n = 0; n < NUM_TIMERS; n++) r_cmp[n] <= 16'hFFFF;
`endif
    end else begin
      r_rd_q    <= w_rd;
      r_ovf     <= w_ovf_nxt;
      r_irq     <= w_irq_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_reload  <= w_reload_nxt;
      r_count   <= w_count_nxt;
      r_staging <= w_staging_nxt;
      r_shadow  <= w_shadow_nxt;
      r_presc   <= w_presc_nxt;
`ifdef TIMER_BLOCK_PWM_EN
      r_pwm     <= w_pwm_nxt;
      r_cmp     <= w_cmp_nxt;
`endif
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    if (bus_addr == 6'h3F) begin
      bus_data_out = ID_VALUE;
    end else begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (w_idx == 3'(n)) begin
          case (w_off)
            3'd0: bus_data_out = {2'b00, r_ctrl[n]};
            3'd1: bus_data_out = r_reload[n][7:0];
            3'd2: bus_data_out = r_reload[n][15:8];
            3'd3: bus_data_out = r_count[n][7:0];
            3'd4: bus_data_out = r_shadow[n];
            3'd5: bus_data_out = {7'b0, r_ovf[n]};
`ifdef TIMER_BLOCK_PWM_EN
            3'd6: bus_data_out = r_cmp[n][7:0];
            3'd7: bus_data_out = r_cmp[n][15:8];
`endif
            default: bus_data_out = 8'h00;
          endcase
        end
      end
    end
  end

  assign irq = r_irq;
`ifdef TIMER_BLOCK_PWM_EN
  assign pwm_out = r_pwm;
`else
  assign pwm_out = '0;
`endif

endmodule

// File: tb/tb_as2650_timer_block.sv
// Scoreboard bench for as2650_timer_block: stimulus queues expectations, a negedge monitor checks.
module tb_as2650_timer_block;

  localparam int NT = 2;
`ifdef TIMER_BLOCK_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic          bus_cyc = 1'b0;
  logic          bus_we = 1'b0;
  logic [5:0]    bus_addr = '0;
  logic [7:0]    bus_data_in = '0;
  logic [7:0]    bus_data_out;
  logic [NT-1:0] irq;
  logic [NT-1:0] pwm_out;
  logic          probe = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string         name;
    bit            cd;
    logic [7:0]    ed;
    bit            ci;
    logic [NT-1:0] ei;
    bit            cp;
    logic [NT-1:0] ep;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;

  as2650_timer_block #(.NUM_TIMERS(NT), .ID_VALUE(8'h54)) dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .bus_cyc     (bus_cyc),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_data_in (bus_data_in),
    .bus_data_out(bus_data_out),
    .irq         (irq),
    .pwm_out     (pwm_out)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk_i) begin
    if ((bus_cyc && !bus_we) || probe) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_sample: got a sample with empty scoreboard, required none");
      end else begin
        m_e = sb_q.pop_front();
        if (m_e.cd) begin
          n_chk++;
          if (bus_data_out !== m_e.ed) begin
            n_fail++;
            $display("FAIL %s data: got %02h required %02h", m_e.name, bus_data_out, m_e.ed);
          end
        end
        if (m_e.ci) begin
          n_chk++;
          if (irq !== m_e.ei) begin
            n_fail++;
            $display("FAIL %s irq: got %b required %b", m_e.name, irq, m_e.ei);
          end
        end
        if (m_e.cp) begin
          n_chk++;
          if (pwm_out !== m_e.ep) begin
            n_fail++;
            $display("FAIL %s pwm: got %b required %b", m_e.name, pwm_out, m_e.ep);
          end
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus_cyc = 1'b1; bus_we = 1'b1; bus_addr = a; bus_data_in = d;
    @(posedge clk_i); #1;
    bus_cyc = 1'b0; bus_we = 1'b0;
  endtask

  task automatic chk(input bit do_rd, input logic [5:0] a, input logic [7:0] ed,
                     input bit ci, input logic [NT-1:0] ei,
                     input bit cp, input logic [NT-1:0] ep, input string name);
    exp_t e;
    e.name = name; e.cd = do_rd; e.ed = ed; e.ci = ci; e.ei = ei; e.cp = cp; e.ep = ep;
    sb_q.push_back(e);
    if (do_rd) begin
      bus_cyc = 1'b1; bus_we = 1'b0; bus_addr = a;
    end else begin
      probe = 1'b1;
    end
    @(posedge clk_i); #1;
    bus_cyc = 1'b0; probe = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] ed, input string name);
    chk(1'b1, a, ed, 1'b0, '0, 1'b0, '0, name);
  endtask

  task automatic rdi(input logic [5:0] a, input logic [7:0] ed, input logic [NT-1:0] ei,
                     input string name);
    chk(1'b1, a, ed, 1'b1, ei, 1'b0, '0, name);
  endtask

  task automatic pi(input logic [NT-1:0] ei, input string name);
    chk(1'b0, 6'h00, 8'h00, 1'b1, ei, 1'b0, '0, name);
  endtask

  task automatic pp(input logic [NT-1:0] ep, input string name);
    chk(1'b0, 6'h00, 8'h00, 1'b0, '0, 1'b1, ep, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [7:0]    ev;
    logic [NT-1:0] pv;
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b0;

    // Reset state of the whole map
    for (int a = 0; a < 64; a++) begin
      if (a == 63)                                          ev = 8'h54;
      else if (PWM && (a == 6 || a == 7 || a == 14 || a == 15)) ev = 8'hFF;
      else                                                  ev = 8'h00;
      rd(6'(a), ev, $sformatf("reset_rd_%02h", a));
    end
    pi(2'b00, "reset_irq");
    pp(2'b00, "reset_pwm");

    // Periodic timer 0 with irq
    wr(6'd1, 8'h03); wr(6'd2, 8'h00); wr(6'd3, 8'h03); wr(6'd4, 8'h00);
    wr(6'd0, 8'h05);
    rdi(6'd3, 8'h03, 2'b00, "t0_cnt3");
    rd(6'd3, 8'h02, "t0_cnt2");
    rd(6'd3, 8'h01, "t0_cnt1");
    rd(6'd3, 8'h00, "t0_cnt0");
    rdi(6'd3, 8'h03, 2'b00, "t0_reload");
    rdi(6'd5, 8'h01, 2'b01, "t0_ovf_irq");
    wr(6'd0, 8'h04);
    wr(6'd5, 8'h01);
    pi(2'b01, "t0_irq_hold");
    pi(2'b00, "t0_irq_drop");
    rd(6'd5, 8'h00, "t0_w1c");

    // One-shot
    wr(6'd1, 8'h05); wr(6'd2, 8'h00); wr(6'd3, 8'h01); wr(6'd4, 8'h00);
    wr(6'd0, 8'h03);
    rd(6'd3, 8'h01, "os_c1");
    rd(6'd3, 8'h00, "os_c0");
    rd(6'd0, 8'h02, "os_en_clr");
    rd(6'd5, 8'h01, "os_ovf");
    rd(6'd3, 8'h05, "os_reload");
    wr(6'd5, 8'h01);
    idle(20);
    rd(6'd5, 8'h00, "os_no_ovf");
    rdi(6'd3, 8'h05, 2'b00, "os_hold");

    // Prescaler on timer 1, PS=3
    wr(6'd9, 8'h07); wr(6'd10, 8'h00); wr(6'd11, 8'h02); wr(6'd12, 8'h00);
    wr(6'd8, 8'h19);
    for (int k = 0; k < 25; k++) begin
      ev = (k < 8) ? 8'h02 : (k < 16) ? 8'h01 : (k < 24) ? 8'h00 : 8'h07;
      rd(6'd11, ev, $sformatf("ps_cnt_%0d", k));
    end
    rd(6'd13, 8'h01, "ps_ovf");
    wr(6'd8, 8'h18);
    wr(6'd8, 8'h19);
    for (int k = 0; k < 9; k++) begin
      ev = (k < 8) ? 8'h07 : 8'h06;
      rd(6'd11, ev, $sformatf("ps_restart_%0d", k));
    end
    wr(6'd8, 8'h00); wr(6'd13, 8'h01);
    rd(6'd13, 8'h00, "t1_ovf_clr");

    // Unmapped write ignored
    wr(6'h10, 8'h07);
    rd(6'h10, 8'h00, "unmapped_wr");

    // Atomic count read
    wr(6'd0, 8'h00);
    wr(6'd3, 8'h00); wr(6'd4, 8'h01);
    wr(6'd0, 8'h01);
    rd(6'd3, 8'h00, "atom_lo");
    idle(5);
    rd(6'd4, 8'h01, "atom_hi");

    // W1C coinciding with OVF set
    wr(6'd3, 8'h02); wr(6'd4, 8'h00);
    idle(2);
    wr(6'd5, 8'h01);
    rd(6'd5, 8'h01, "w1c_vs_set");
    rd(6'd3, 8'h04, "count_after_ovf");
    wr(6'd0, 8'h00); wr(6'd5, 8'h01);

    // Compare output on timer 0
    wr(6'd1, 8'h09); wr(6'd2, 8'h00); wr(6'd6, 8'h04); wr(6'd7, 8'h00);
    wr(6'd3, 8'h09); wr(6'd4, 8'h00);
    wr(6'd0, 8'h01);
    for (int k = 0; k < 20; k++) begin
      pv = (PWM && k >= 1 && ((k - 1) % 10) >= 6) ? 2'b01 : 2'b00;
      pp(pv, $sformatf("pwm_%0d", k));
    end
    rd(6'd6, PWM ? 8'h04 : 8'h00, "cmp_rd");
    wr(6'd0, 8'h00);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk_i);
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
